// File: rtl/simon_pkg.sv
//------------------------------------------------------------------------------
// Module  : simon_pkg
// Brief   : Shared types and constants for the Simon game controller.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package simon_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_gap   = 3'd1;
    localparam state_t c_st_flash = 3'd2;
    localparam state_t c_st_input = 3'd3;
    localparam state_t c_st_msg   = 3'd4;

    // x^8+x^6+x^5+x^4+1, taps on q[7], q[5], q[4], q[3]
    localparam logic [7:0] c_lfsr_taps = 8'hB8;

    localparam logic [1:0] c_led_none  = 2'b00;
    localparam logic [1:0] c_led_left  = 2'b10;
    localparam logic [1:0] c_led_right = 2'b01;

    localparam logic c_result_win  = 1'b1;
    localparam logic c_result_lose = 1'b0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & c_lfsr_taps)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/simon_lfsr.sv
//------------------------------------------------------------------------------
// Module  : simon_lfsr
// Brief   : Free-running 8-bit Fibonacci LFSR, steps every clock.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [7:0] q
);

    logic [7:0] lfsr_d;
    logic [7:0] lfsr_q;

    // A non-zero seed keeps the sequence off the all-zero lock-up state.
    always_comb lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/simon_game_ctrl.sv
//------------------------------------------------------------------------------
// Module  : simon_game_ctrl
// Brief   : Simon memory-game sequencer; optional input-idle timeout enabled
//           by defining SIMON_TIMEOUT_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int         MAX_BITS    = 8,
    parameter int         TIMEOUT_CYC = 500000000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       flash_done,
    input  logic       msg_done,
    output logic       flash_enable,
    output logic [2:0] bit_count,
    output logic [7:0] bit_gen,
    output logic       msg_start,
    output logic       win,
    output logic [1:0] input_led
);

    localparam logic [2:0] c_last_bit = 3'(MAX_BITS - 1);

    state_t     state_d, state_q;
    logic [2:0] bit_count_d, bit_count_q;
    logic [7:0] bit_gen_d, bit_gen_q;
    logic       win_d, win_q;
    logic [2:0] idx_d, idx_q;
    logic [1:0] input_led_d, input_led_q;

    logic [7:0] w_lfsr;
    logic       w_press;
    logic       w_match;
    logic       w_timeout;

    simon_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .q       (w_lfsr)
    );

    assign w_press = btn_left | btn_right;
    // Both buttons at once never counts as a valid entry.
    assign w_match = (btn_left ^ btn_right) && (btn_right == bit_gen_q[idx_q]);

`ifdef SIMON_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_cnt_w-1:0] tmo_cnt_d, tmo_cnt_q;

    assign w_timeout = (tmo_cnt_q == c_cnt_w'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == c_st_input && !w_press && !w_timeout)
            tmo_cnt_d = tmo_cnt_q + c_cnt_w'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tmo_cnt_q <= '0;
        else          tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        bit_gen_d   = bit_gen_q;
        win_d       = win_q;
        idx_d       = idx_q;
        input_led_d = c_led_none;
        case (state_q)
            c_st_idle: begin
                if (start) begin
                    bit_gen_d   = w_lfsr;
                    bit_count_d = 3'd0;
                    win_d       = c_result_lose;
                    state_d     = c_st_gap;
                end
            end
            // One cycle with flash_enable low lets the flash block rewind.
            c_st_gap:   state_d = c_st_flash;
            c_st_flash: begin
                if (flash_done) begin
                    idx_d   = 3'd0;
                    state_d = c_st_input;
                end
            end
            c_st_input: begin
                if (w_press) begin
                    if (btn_left && !btn_right)      input_led_d = c_led_left;
                    else if (btn_right && !btn_left) input_led_d = c_led_right;
                    if (!w_match) begin
                        win_d   = c_result_lose;
                        state_d = c_st_msg;
                    end else if (idx_q < bit_count_q) begin
                        idx_d = idx_q + 3'd1;
                    end else if (bit_count_q != c_last_bit) begin
                        bit_count_d = bit_count_q + 3'd1;
                        state_d     = c_st_gap;
                    end else begin
                        win_d   = c_result_win;
                        state_d = c_st_msg;
                    end
                end else if (w_timeout) begin
                    win_d   = c_result_lose;
                    state_d = c_st_msg;
                end
            end
            c_st_msg: begin
                if (msg_done) state_d = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= c_st_idle;
            bit_count_q <= 3'd0;
            bit_gen_q   <= 8'd0;
            win_q       <= 1'b0;
            idx_q       <= 3'd0;
            input_led_q <= c_led_none;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            bit_gen_q   <= bit_gen_d;
            win_q       <= win_d;
            idx_q       <= idx_d;
            input_led_q <= input_led_d;
        end
    end

    assign flash_enable = (state_q == c_st_flash);
    assign msg_start    = (state_q == c_st_msg);
    assign bit_count    = bit_count_q;
    assign bit_gen      = bit_gen_q;
    assign win          = win_q;
    assign input_led    = input_led_q;

endmodule

`default_nettype wire

// File: tb/tb_simon_game_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_simon_game_ctrl
// Brief   : Directed self-checking bench for simon_game_ctrl.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_simon_game_ctrl;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       btn_left;
    logic       btn_right;
    logic       flash_done;
    logic       msg_done;
    logic       flash_enable;
    logic [2:0] bit_count;
    logic [7:0] bit_gen;
    logic       msg_start;
    logic       win;
    logic [1:0] input_led;

    int n_pass  = 0;
    int n_total = 0;

    // State encodings: IDLE=0 GAP=1 FLASH=2 INPUT=3 MSG=4
    localparam int ST_IDLE  = 0;
    localparam int ST_GAP   = 1;
    localparam int ST_FLASH = 2;
    localparam int ST_INPUT = 3;
    localparam int ST_MSG   = 4;

    simon_game_ctrl #(
        .MAX_BITS    (8),
        .TIMEOUT_CYC (100),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .flash_done   (flash_done),
        .msg_done     (msg_done),
        .flash_enable (flash_enable),
        .bit_count    (bit_count),
        .bit_gen      (bit_gen),
        .msg_start    (msg_start),
        .win          (win),
        .input_led    (input_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic b);
        btn_left  = ~b;
        btn_right = b;
        tick();
        btn_left  = 1'b0;
        btn_right = 1'b0;
        check("input_led", input_led, {~b, b});
    endtask

    // Returns with the DUT just entered INPUT.
    task automatic enter_input();
        for (int i = 0; i < 20 && flash_enable !== 1'b1; i++) tick();
        check("flash_en", flash_enable, 1);
        tick();
        flash_done = 1'b1;
        tick();
        flash_done = 1'b0;
    endtask

    task automatic play_level(input logic [7:0] pat, input int lvl);
        enter_input();
        for (int i = 0; i < lvl; i++) press(pat[i]);
    endtask

    task automatic finish_msg();
        msg_done = 1'b1;
        tick();
        msg_done = 1'b0;
    endtask

    // Reset, then release together with start so the seed A5 is latched.
    task automatic reset_and_start();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        flash_done = 1'b0;
        msg_done   = 1'b0;
        repeat (3) tick();

        check("rst_flash_en",  flash_enable, 0);
        check("rst_msg_start", msg_start,    0);
        check("rst_win",       win,          0);
        check("rst_bit_count", bit_count,    0);
        check("rst_bit_gen",   bit_gen,      0);
        check("rst_input_led", input_led,    0);
        check("rst_state",     dut.state_q,  ST_IDLE);

        // Full 8-level win with pattern A5 = bits 1,0,1,0,0,1,0,1
        reset_n = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("win_bit_gen", bit_gen, 8'hA5);
        check("win_gap",     dut.state_q, ST_GAP);
        for (int lvl = 1; lvl <= 8; lvl++) begin
            check("win_level_count", bit_count, lvl - 1);
            play_level(8'hA5, lvl);
        end
        check("win_win",       win,         1);
        check("win_msg_start", msg_start,   1);
        check("win_state_msg", dut.state_q, ST_MSG);
        check("win_count7",    bit_count,   7);
        tick();
        check("win_led_clear", input_led,   0);
        repeat (3) tick();
        check("win_msg_hold",  msg_start,   1);
        finish_msg();
        check("win_idle",      dut.state_q, ST_IDLE);
        check("win_msg_drop",  msg_start,   0);
        check("win_held",      win,         1);

        // Level-3 wrong press: pattern 4A = bits 0,1,0,1,...
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lose_bit_gen", bit_gen, 8'h4A);
        play_level(8'h4A, 1);
        play_level(8'h4A, 2);
        check("lose_count2", bit_count, 2);
        enter_input();
        press(1'b0);
        check("lose_idx0_ok", dut.state_q, ST_INPUT);
        press(1'b0);
        check("lose_win",       win,         0);
        check("lose_state_msg", dut.state_q, ST_MSG);
        check("lose_msg_start", msg_start,   1);
        check("lose_count",     bit_count,   2);
        finish_msg();
        check("lose_idle", dut.state_q, ST_IDLE);

        // Both buttons together count as a miss.
        start = 1'b1;
        tick();
        start = 1'b0;
        enter_input();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        tick();
        btn_left  = 1'b0;
        btn_right = 1'b0;
        check("both_state",     dut.state_q, ST_MSG);
        check("both_msg_start", msg_start,   1);
        check("both_win",       win,         0);
        finish_msg();

        // Presses during FLASH and start during INPUT are ignored.
        reset_and_start();
        tick();
        check("ign_in_flash", dut.state_q, ST_FLASH);
        btn_left = 1'b1;
        tick();
        btn_left  = 1'b0;
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        check("ign_flash_state", dut.state_q, ST_FLASH);
        check("ign_flash_gen",   bit_gen,     8'hA5);
        check("ign_flash_led",   input_led,   0);
        flash_done = 1'b1;
        tick();
        flash_done = 1'b0;
        check("ign_input", dut.state_q, ST_INPUT);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_start_state", dut.state_q, ST_INPUT);
        check("ign_start_gen",   bit_gen,     8'hA5);
        check("ign_start_count", bit_count,   0);
        press(1'b1);
        check("ign_level_up", bit_count, 1);

        // Asynchronous reset while flashing level 2.
        for (int i = 0; i < 20 && flash_enable !== 1'b1; i++) tick();
        check("arst_pre_flash", flash_enable, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_flash_en",  flash_enable, 0);
        check("arst_msg_start", msg_start,    0);
        check("arst_win",       win,          0);
        check("arst_bit_count", bit_count,    0);
        check("arst_bit_gen",   bit_gen,      0);
        check("arst_input_led", input_led,    0);
        check("arst_state",     dut.state_q,  ST_IDLE);
        tick();
        reset_n = 1'b1;
        tick();

`ifdef SIMON_TIMEOUT_EN
        // No press: MSG after 100 cycles in INPUT.
        reset_and_start();
        enter_input();
        repeat (99) tick();
        check("tmo_still_input", dut.state_q, ST_INPUT);
        tick();
        check("tmo_state",     dut.state_q, ST_MSG);
        check("tmo_win",       win,         0);
        check("tmo_msg_start", msg_start,   1);
        finish_msg();

        // A press on the 99th cycle restarts the count.
        reset_and_start();
        play_level(8'hA5, 1);
        enter_input();
        repeat (98) tick();
        press(1'b1);
        check("tmo_press_input", dut.state_q, ST_INPUT);
        repeat (99) tick();
        check("tmo_restart_input", dut.state_q, ST_INPUT);
        tick();
        check("tmo_restart_msg", dut.state_q, ST_MSG);
        finish_msg();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
